// File: rtl/render_pkg.sv
// ============================================================================
// render_pkg : shared types and register map for the render instruction queue
// Revision   : 1.0
// ============================================================================
`default_nettype none

package render_pkg;

    localparam logic [7:0] VGA_DO_RENDER = 8'hFF;

    typedef struct packed {
        logic [7:0]  magic;
        logic [15:0] x;
        logic [15:0] y;
        logic [7:0]  flags;
    } rq_instr_t;

    localparam logic [1:0] RQ_REG_LO     = 2'd0;
    localparam logic [1:0] RQ_REG_HI     = 2'd1;
    localparam logic [1:0] RQ_REG_STATUS = 2'd2;
    localparam logic [1:0] RQ_REG_CTRL   = 2'd3;

    localparam int ST_FULL_BIT  = 31;
    localparam int ST_EMPTY_BIT = 30;
    localparam int ST_OVF_BIT   = 29;
    localparam int ST_UNF_BIT   = 28;

    localparam int CTRL_FLUSH_BIT  = 0;
    localparam int CTRL_CLR_BIT    = 1;
    localparam int CTRL_COMMIT_BIT = 2;

endpackage

`default_nettype wire

// File: rtl/rq_storage.sv
// ============================================================================
// rq_storage : DEPTH x 48 register file, synchronous write, asynchronous read
// Revision   : 1.0
// ============================================================================
`default_nettype none

module rq_storage
    import render_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk50,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  rq_instr_t         wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output rq_instr_t         rdata_o
);

    rq_instr_t mem_q [DEPTH];

    always_ff @(posedge clk50) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/render_queue_writer.sv
// ============================================================================
// render_queue_writer : Avalon-MM slave queuing 48-bit sprite render words
// Optional macro      : RQ_FRAME_COMMIT_EN (pushes held back until commit)
// Revision            : 1.0
// ============================================================================
`default_nettype none

module render_queue_writer
    import render_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic        clk50,
    input  logic        reset,
    input  logic        chipselect,
    input  logic        write,
    input  logic        read,
    input  logic [1:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [47:0] render_queue_dout,
    input  logic        render_queue_pop_front
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
    localparam rq_instr_t       PARK_WORD = '{magic: VGA_DO_RENDER, default: '0};

    logic [ADDR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [ADDR_W:0]   count_q, count_d;
    logic [31:0]       stage_lo_q, readdata_q;
    logic [15:0]       stage_hi_q;
    logic              ovf_q, unf_q;

    logic        w_wr_lo, w_wr_hi, w_ctrl, w_flush, w_clr, w_rd_en;
    logic        w_full, w_empty, w_pop_ok, w_push_ok;
    logic [11:0] w_pend12;
    logic [31:0] w_status, w_rdata;
    rq_instr_t   w_head;

    assign w_wr_lo = chipselect & write & (address == RQ_REG_LO);
    assign w_wr_hi = chipselect & write & (address == RQ_REG_HI);
    assign w_ctrl  = chipselect & write & (address == RQ_REG_CTRL);
    assign w_flush = w_ctrl & writedata[CTRL_FLUSH_BIT];
    assign w_clr   = w_ctrl & writedata[CTRL_CLR_BIT];
    assign w_rd_en = chipselect & read;

`ifdef RQ_FRAME_COMMIT_EN
    logic [ADDR_W:0] pending_q, pending_d;
    logic            w_commit;

    assign w_commit = w_ctrl & writedata[CTRL_COMMIT_BIT];
    // Space is judged on everything written, committed or not
    assign w_full   = (count_q + pending_q) == FULL_CNT;
    assign w_pend12 = 12'(pending_q);
`else
    assign w_full   = count_q == FULL_CNT;
    assign w_pend12 = '0;
`endif

    assign w_empty   = count_q == '0;
    assign w_pop_ok  = render_queue_pop_front & ~w_empty & ~w_flush;
    assign w_push_ok = w_wr_hi & (~w_full | w_pop_ok);

    always_comb begin
        count_d = count_q;
`ifdef RQ_FRAME_COMMIT_EN
        pending_d = pending_q + (ADDR_W+1)'(w_push_ok);
        if (w_commit) begin
            count_d   = count_q + pending_q;
            pending_d = '0;
        end
        if (w_pop_ok) begin
            count_d = count_d - (ADDR_W+1)'(1);
        end
`else
        if (w_push_ok && !w_pop_ok) begin
            count_d = count_q + (ADDR_W+1)'(1);
        end else if (!w_push_ok && w_pop_ok) begin
            count_d = count_q - (ADDR_W+1)'(1);
        end
`endif
    end

    always_comb begin
        w_status               = '0;
        w_status[ST_FULL_BIT]  = w_full;
        w_status[ST_EMPTY_BIT] = w_empty;
        w_status[ST_OVF_BIT]   = ovf_q;
        w_status[ST_UNF_BIT]   = unf_q;
        w_status[27:16]        = w_pend12;
        w_status[15:0]         = 16'(count_q);
        case (address)
            RQ_REG_LO:     w_rdata = stage_lo_q;
            RQ_REG_HI:     w_rdata = {16'h0000, stage_hi_q};
            RQ_REG_STATUS: w_rdata = w_status;
            default:       w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            stage_lo_q <= '0;
            stage_hi_q <= '0;
            readdata_q <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
`ifdef RQ_FRAME_COMMIT_EN
            pending_q  <= '0;
`endif
        end else begin
            if (w_rd_en) readdata_q <= w_rdata;
            if (w_wr_lo) stage_lo_q <= writedata;
            if (w_wr_hi) stage_hi_q <= writedata[15:0];

            if (w_flush) begin
                rd_ptr_q  <= '0;
                wr_ptr_q  <= '0;
                count_q   <= '0;
`ifdef RQ_FRAME_COMMIT_EN
                pending_q <= '0;
`endif
            end else begin
                if (w_push_ok) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
                if (w_pop_ok)  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
                count_q <= count_d;
`ifdef RQ_FRAME_COMMIT_EN
                pending_q <= pending_d;
`endif
            end

            // A same-cycle error event outranks the clear request
            if (w_clr) begin
                ovf_q <= 1'b0;
                unf_q <= 1'b0;
            end
            if (w_wr_hi && !w_push_ok) ovf_q <= 1'b1;
            if (render_queue_pop_front && w_empty && !w_flush) unf_q <= 1'b1;
        end
    end

    rq_storage #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_storage (
        .clk50   (clk50),
        .we_i    (w_push_ok),
        .waddr_i (wr_ptr_q),
        .wdata_i ({writedata[15:0], stage_lo_q}),
        .raddr_i (rd_ptr_q),
        .rdata_o (w_head)
    );

    assign readdata          = readdata_q;
    assign render_queue_dout = w_empty ? PARK_WORD : w_head;

endmodule

`default_nettype wire
